// File: rtl/cnna_axislv_pkg.sv
// Shared response codes, FSM encodings and back-pressure LFSR constants
// for the axislv_ddr_ram AXI slave memory model.
package cnna_axislv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axislv_skid.sv
// Two-entry valid/ready FIFO that buffers RAM read data in front of the
// R channel; exposes its occupancy so the issuer can avoid overflow.
module axislv_skid #(
  parameter int W = 129
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_slot [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push & (r_occ != 2'd2);
  assign w_pop  = i_pop & (r_occ != 2'd0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge i_clk) begin
      if (i_rst)
        r_slot[gi] <= '0;
      else if (w_push && (r_wr_ptr == 1'(gi)))
        r_slot[gi] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_ready = (r_occ != 2'd2);
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_slot[r_rd_ptr];
  assign o_occ   = r_occ;

endmodule

// File: rtl/sdpram.sv
// Simple dual-port block RAM, one clock, registered read. A read and a
// write to the same word in one cycle return the old contents.
module sdpram #(
  parameter int AW = 12,
  parameter int DW = 128
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axislv_ddr_ram.sv
// AXI4 slave memory model: independent write and read INCR-burst FSMs over an sdpram.
// Define CNNA_AXISLV_BP_EN to add LFSR-driven back-pressure on the slave handshakes.
module axislv_ddr_ram
  import cnna_axislv_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_LEN_WIDTH  = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_MEM_AWIDTH       = 12
) (
  input  logic                            I_clk,
  input  logic                            I_rst,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     I_saxi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   I_saxi_awaddr,
  input  logic [C_S_AXI_LEN_WIDTH-1:0]    I_saxi_awlen,
  input  logic                            I_saxi_awvalid,
  output logic                            O_saxi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   I_saxi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] I_saxi_wstrb,
  input  logic                            I_saxi_wlast,
  input  logic                            I_saxi_wvalid,
  output logic                            O_saxi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     O_saxi_bid,
  output logic [1:0]                      O_saxi_bresp,
  output logic                            O_saxi_bvalid,
  input  logic                            I_saxi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     I_saxi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   I_saxi_araddr,
  input  logic [C_S_AXI_LEN_WIDTH-1:0]    I_saxi_arlen,
  input  logic                            I_saxi_arvalid,
  output logic                            O_saxi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     O_saxi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   O_saxi_rdata,
  output logic [1:0]                      O_saxi_rresp,
  output logic                            O_saxi_rlast,
  output logic                            O_saxi_rvalid,
  input  logic                            I_saxi_rready,
  output logic                            O_wlast_err
);

  localparam int B   = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int CW  = C_S_AXI_LEN_WIDTH + 1;
  localparam int AW  = C_MEM_AWIDTH;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int IDW = C_S_AXI_ID_WIDTH;
  localparam int LW  = C_S_AXI_LEN_WIDTH;

  logic [2:0]    w_bp;
  logic          w_rv_en;

  wr_state_t     r_wstate;
  logic          r_awready;
  logic          r_wready;
  logic          r_bvalid;
  logic          r_wlast_err;
  logic [IDW-1:0] r_bid;
  logic [AW-1:0] r_waddr;
  logic [LW-1:0] r_wlen;
  logic [CW-1:0] r_wcnt;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_wfinal;
  logic [AW-1:0] w_aw_word;

  rd_state_t     r_rstate;
  logic          r_arready;
  logic [IDW-1:0] r_rid;
  logic [AW-1:0] r_raddr;
  logic [LW-1:0] r_rlen;
  logic [CW-1:0] r_issued;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_room;
  logic          w_issue_data;
  logic          w_issue_last;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_ar_word;
  logic [DW-1:0] w_ram_rdata;
  logic          w_skid_valid;
  logic          w_skid_ready;
  logic [DW:0]   w_skid_data;
  logic [1:0]    w_skid_occ;
  logic          w_unused;

`ifdef CNNA_AXISLV_BP_EN
  logic [15:0] r_lfsr;
  logic        r_rv_hold;

  // Once rvalid has been shown it must stay up until taken.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_lfsr    <= LFSR_SEED;
      r_rv_hold <= 1'b0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (w_r_hs)
        r_rv_hold <= 1'b0;
      else if (O_saxi_rvalid)
        r_rv_hold <= 1'b1;
    end
  end

  assign w_bp    = r_lfsr[2:0];
  assign w_rv_en = r_lfsr[3] | r_rv_hold;
`else
  assign w_bp    = 3'b111;
  assign w_rv_en = 1'b1;
`endif

  assign w_aw_word = I_saxi_awaddr[AW+B-1:B];
  assign w_ar_word = I_saxi_araddr[AW+B-1:B];

  assign O_saxi_awready = r_awready & w_bp[0];
  assign O_saxi_wready  = r_wready & w_bp[1];
  assign O_saxi_arready = r_arready & w_bp[2];
  assign O_saxi_bid     = r_bid;
  assign O_saxi_bresp   = RESP_OKAY;
  assign O_saxi_bvalid  = r_bvalid;
  assign O_wlast_err    = r_wlast_err;

  assign w_aw_hs  = I_saxi_awvalid & O_saxi_awready;
  assign w_w_hs   = (r_wstate == W_DATA) & I_saxi_wvalid & O_saxi_wready;
  assign w_b_hs   = r_bvalid & I_saxi_bready;
  assign w_wfinal = (r_wcnt == CW'(r_wlen));

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_wlast_err <= 1'b0;
      r_bid       <= '0;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= I_saxi_awid;
            r_waddr   <= w_aw_word;
            r_wlen    <= I_saxi_awlen;
            r_wcnt    <= '0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_waddr <= r_waddr + AW'(1);
            r_wcnt  <= r_wcnt + CW'(1);
            // The beat count, not wlast, decides where the burst ends.
            if (I_saxi_wlast != w_wfinal) r_wlast_err <= 1'b1;
            if (w_wfinal) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign O_saxi_rvalid = w_skid_valid & w_rv_en;
  assign O_saxi_rdata  = w_skid_data[DW-1:0];
  assign O_saxi_rlast  = w_skid_valid & w_skid_data[DW];
  assign O_saxi_rid    = r_rid;
  assign O_saxi_rresp  = RESP_OKAY;

  assign w_ar_hs = I_saxi_arvalid & O_saxi_arready;
  assign w_r_hs  = O_saxi_rvalid & I_saxi_rready;

  // Count this cycle's pop as free space so a steady stream never bubbles.
  assign w_room = ({1'b0, w_skid_occ} + {2'b00, r_inflight} - {2'b00, w_r_hs}) < 3'd2;
  assign w_issue_data = (r_rstate == R_DATA) && (r_issued <= CW'(r_rlen)) && w_room;

  // The first beat is read in the AR handshake cycle itself.
  assign w_rd_en      = w_ar_hs | w_issue_data;
  assign w_rd_addr    = w_ar_hs ? w_ar_word : r_raddr;
  assign w_issue_last = w_ar_hs ? (I_saxi_arlen == '0) : (r_issued == CW'(r_rlen));

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rstate        <= R_IDLE;
      r_arready       <= 1'b0;
      r_rid           <= '0;
      r_raddr         <= '0;
      r_rlen          <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en & w_issue_last;
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= I_saxi_arid;
            r_raddr   <= w_ar_word + AW'(1);
            r_rlen    <= I_saxi_arlen;
            r_issued  <= CW'(1);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_issue_data) begin
            r_raddr  <= r_raddr + AW'(1);
            r_issued <= r_issued + CW'(1);
          end
          if (w_r_hs && O_saxi_rlast) begin
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  sdpram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .i_clk   (I_clk),
    .i_we    (w_w_hs),
    .i_waddr (r_waddr),
    .i_wdata (I_saxi_wdata),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  axislv_skid #(
    .W (DW + 1)
  ) u_skid (
    .i_clk   (I_clk),
    .i_rst   (I_rst),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, w_ram_rdata}),
    .o_ready (w_skid_ready),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .i_pop   (w_r_hs),
    .o_occ   (w_skid_occ)
  );

  // Strobes and out-of-range address bits are intentionally ignored.
  assign w_unused = ^{I_saxi_wstrb, I_saxi_awaddr, I_saxi_araddr, w_skid_ready};

endmodule

// File: tb/tb_axislv_ddr_ram.sv
// Scoreboard bench for axislv_ddr_ram: stimulus pushes expected R/B responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axislv_ddr_ram;

  localparam int IDW = 1;
  localparam int LW  = 8;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int MAW = 12;
  localparam int DEPTH = 1 << MAW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IDW-1:0]  awid = '0;
  logic [AW-1:0]   awaddr = '0;
  logic [LW-1:0]   awlen = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '1;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b1;
  logic [IDW-1:0]  arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [LW-1:0]   arlen = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b1;
  logic            wlast_err;

  always #5 clk = ~clk;

  axislv_ddr_ram #(
    .C_S_AXI_ID_WIDTH   (IDW),
    .C_S_AXI_LEN_WIDTH  (LW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_S_AXI_DATA_WIDTH (DW),
    .C_MEM_AWIDTH       (MAW)
  ) dut (
    .I_clk          (clk),
    .I_rst          (rst),
    .I_saxi_awid    (awid),
    .I_saxi_awaddr  (awaddr),
    .I_saxi_awlen   (awlen),
    .I_saxi_awvalid (awvalid),
    .O_saxi_awready (awready),
    .I_saxi_wdata   (wdata),
    .I_saxi_wstrb   (wstrb),
    .I_saxi_wlast   (wlast),
    .I_saxi_wvalid  (wvalid),
    .O_saxi_wready  (wready),
    .O_saxi_bid     (bid),
    .O_saxi_bresp   (bresp),
    .O_saxi_bvalid  (bvalid),
    .I_saxi_bready  (bready),
    .I_saxi_arid    (arid),
    .I_saxi_araddr  (araddr),
    .I_saxi_arlen   (arlen),
    .I_saxi_arvalid (arvalid),
    .O_saxi_arready (arready),
    .O_saxi_rid     (rid),
    .O_saxi_rdata   (rdata),
    .O_saxi_rresp   (rresp),
    .O_saxi_rlast   (rlast),
    .O_saxi_rvalid  (rvalid),
    .I_saxi_rready  (rready),
    .O_wlast_err    (wlast_err)
  );

  typedef struct packed {
    logic [DW-1:0]  data;
    logic           last;
    logic [IDW-1:0] id;
  } rexp_t;

  rexp_t          exp_r[$];
  logic [IDW-1:0] exp_b[$];
  logic [DW-1:0]  model [0:DEPTH-1];
  int             vec_cnt = 0;
  int             fail_cnt = 0;
  bit             sb_mute = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    vec_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name, input int cycles);
    vec_cnt++;
    fail_cnt++;
    $display("FAIL %s: no response after %0d cycles, required within bound", name, cycles);
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp,
                 rlast, wlast_err, rdata});
  endfunction

  // Monitor: compares every R and B handshake against the scoreboard queues.
  initial begin
    rexp_t          e;
    logic [IDW-1:0] eb;
    logic [DW-1:0]  prev_data = '0;
    logic           prev_last = 1'b0;
    logic           prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || sb_mute) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("r_hold", 160'({rvalid, rlast, rdata}), 160'({1'b1, prev_last, prev_data}));
        if (rvalid && rready) begin
          if (exp_r.size() == 0) begin
            vec_cnt++;
            fail_cnt++;
            $display("FAIL r_unexpected: got beat %h, required none", rdata);
          end else begin
            e = exp_r.pop_front();
            check("r_beat", 160'({rid, rresp, rlast, rdata}), 160'({e.id, 2'b00, e.last, e.data}));
          end
        end
        prev_stall = rvalid && !rready;
        prev_data  = rdata;
        prev_last  = rlast;
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            vec_cnt++;
            fail_cnt++;
            $display("FAIL b_unexpected: got bid %h, required none", bid);
          end else begin
            eb = exp_b.pop_front();
            check("b_resp", 160'({bid, bresp}), 160'({eb, 2'b00}));
          end
        end
      end
    end
  end

  // which: 0=awready 1=wready 2=arready; returns at posedge+1 after the handshake
  task automatic wait_rdy(input int which, input string name);
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 100) begin
      @(negedge clk);
      t++;
      case (which)
        0:       ok = awready;
        1:       ok = wready;
        default: ok = arready;
      endcase
    end
    if (!ok) timeout_fail(name, t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input int word, input int nbeats,
                          input logic [DW-1:0] base, input int wlast_beat);
    int t;
    exp_b.push_back(id);
    awid    = id;
    awaddr  = AW'(word) << 4;
    awlen   = LW'(nbeats - 1);
    awvalid = 1'b1;
    wait_rdy(0, "aw_ready");
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata  = base + DW'(i);
      wlast  = (i == wlast_beat);
      wvalid = 1'b1;
      wait_rdy(1, "w_ready");
      model[(word + i) % DEPTH] = base + DW'(i);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    t = 0;
    while (exp_b.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_b.size() != 0) timeout_fail("b_wait", t);
    @(posedge clk);
    #1;
  endtask

  // pat gives rready for the 6 cycles starting 2 cycles after the AR handshake.
  task automatic do_read(input logic [IDW-1:0] id, input int word, input int len,
                         input logic [5:0] pat, input bit chk_lat, input bit chk_stream);
    int c;
    int first_c = -1;
    int last_c  = -1;
    bit done = 1'b0;
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.data = model[(word + i) % DEPTH];
      e.last = (i == len);
      e.id   = id;
      exp_r.push_back(e);
    end
    arid    = id;
    araddr  = AW'(word) << 4;
    arlen   = LW'(len);
    arvalid = 1'b1;
    rready  = 1'b1;
    wait_rdy(2, "ar_ready");
    arvalid = 1'b0;
    c = 1;
    while (!done && c < 2000) begin
      rready = (c >= 2 && c < 8) ? pat[c-2] : 1'b1;
      @(negedge clk);
      if (rvalid && first_c < 0) first_c = c;
      if (rvalid && rready && rlast) begin
        done   = 1'b1;
        last_c = c;
      end
      @(posedge clk);
      #1;
      c++;
    end
    rready = 1'b1;
    if (!done) timeout_fail("r_last_wait", c);
    if (chk_lat)    check("r_first_latency", 160'(first_c), 160'(2));
    if (chk_stream) check("r_stream_cycles", 160'(last_c - first_c + 1), 160'(256));
  endtask

  initial begin
    int n;
    int t;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill words 0..255, then the 4-beat burst at byte 0x100 (word 0x10)
    do_write(1'b0, 0, 256, 128'h1000, 255);
    do_write(1'b1, 16, 4, 128'hA0, 3);
    check("wlast_err_clean", 160'(wlast_err), 160'(0));
    do_read(1'b1, 16, 3, 6'b111111, 1'b1, 1'b0);

    // 256-beat stream with rready held high
    do_read(1'b0, 0, 255, 6'b111111, 1'b1, 1'b1);

    // rready toggling 1,0,0,1,0,1
    do_read(1'b1, 32, 2, 6'b101001, 1'b0, 1'b0);

    // wlast early on beat 1 of 2: error flag, exactly two words written
    do_write(1'b0, 64, 2, 128'hB0, 0);
    check("wlast_err_set", 160'(wlast_err), 160'(1));
    repeat (4) @(posedge clk);
    #1;
    do_read(1'b0, 64, 2, 6'b111111, 1'b0, 1'b0);

    // Address wrap from the top word to word 0
    do_write(1'b1, DEPTH - 1, 2, 128'hC0, 1);
    do_read(1'b1, DEPTH - 1, 1, 6'b111111, 1'b0, 1'b0);
    do_read(1'b0, 0, 0, 6'b111111, 1'b0, 1'b0);

    // Reset during beat 2 of an 8-beat read
    sb_mute = 1'b1;
    arid    = 1'b1;
    araddr  = '0;
    arlen   = LW'(7);
    arvalid = 1'b1;
    rready  = 1'b1;
    wait_rdy(2, "ar_ready_rst");
    arvalid = 1'b0;
    n = 0;
    t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (rvalid) n++;
    end
    if (n < 2) timeout_fail("rst_beat2_wait", t);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_mid_burst_outputs", all_outs(), '0);
    rst = 1'b0;
    exp_r.delete();
    sb_mute = 1'b0;
    @(posedge clk);
    #1;
    do_read(1'b1, 5, 0, 6'b111111, 1'b1, 1'b0);
    do_read(1'b0, 16, 0, 6'b111111, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("r_queue_drained", 160'(exp_r.size()), 160'(0));
    check("b_queue_drained", 160'(exp_b.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axislv_ddr_ram.md
Name: axislv_ddr_ram

Overview:
- AXI4 slave memory model that answers the read and write bursts issued by the cnna AXI master blocks.
- Stands in for the DDR chip in block-level and system-level simulation, and can be synthesised as an on-chip DDR substitute.
- Holds a single-clock sdpram with separate, fully independent read and write channel FSMs.
- One outstanding burst per direction; INCR bursts of 1..256 beats.

Parameters:
- C_S_AXI_ID_WIDTH, 1: ID width; IDs are echoed back on responses.
- C_S_AXI_LEN_WIDTH, 8: AxLEN width.
- C_S_AXI_ADDR_WIDTH, 32: byte address width.
- C_S_AXI_DATA_WIDTH, 128: data width in bits; must be a power of 2, minimum 32.
- C_MEM_AWIDTH, 12: word-address width; memory depth is 2^C_MEM_AWIDTH words.

Ports:
- I_clk  in  1  single clock.
- I_rst  in  1  synchronous reset, active-high.
- I_saxi_awid  in  ID  write ID.
- I_saxi_awaddr  in  ADDR  write byte address.
- I_saxi_awlen  in  LEN  write beats minus 1.
- I_saxi_awvalid  in  1; O_saxi_awready  out  1: write-address handshake.
- I_saxi_wdata  in  DATA  write data.
- I_saxi_wstrb  in  DATA/8  write strobes; ignored, full-word writes.
- I_saxi_wlast  in  1  last write beat.
- I_saxi_wvalid  in  1; O_saxi_wready  out  1: write-data handshake.
- O_saxi_bid  out  ID  echoed AWID.
- O_saxi_bresp  out  2  always 2'b00 (OKAY).
- O_saxi_bvalid  out  1; I_saxi_bready  in  1: write-response handshake.
- I_saxi_arid  in  ID  read ID.
- I_saxi_araddr  in  ADDR  read byte address.
- I_saxi_arlen  in  LEN  read beats minus 1.
- I_saxi_arvalid  in  1; O_saxi_arready  out  1: read-address handshake.
- O_saxi_rid  out  ID  echoed ARID.
- O_saxi_rdata  out  DATA  read data.
- O_saxi_rresp  out  2  always 2'b00 (OKAY).
- O_saxi_rlast  out  1  last read beat.
- O_saxi_rvalid  out  1; I_saxi_rready  in  1: read-data handshake.
- O_wlast_err  out  1  sticky; set when I_saxi_wlast disagrees with the beat count.

Behaviour:
- Reset values: all outputs 0. Reset mid-burst aborts both FSMs to IDLE on the next edge; RAM contents are preserved.
- Word address = addr[C_MEM_AWIDTH+B-1:B], where B = log2(DATA/8). Low B bits are ignored. Address increments by 1 word per beat and wraps modulo the memory depth. AxBURST is not decoded; every burst is INCR. Beat counters are 9 bits.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, word address and len; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes wdata the same edge and increments address and counter. On beat len+1, go to W_RESP.
  - wlast on an earlier beat, or missing on the final beat: set O_wlast_err. The burst still ends on the count.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
  - AW handshake to first possible W write: 1 cycle. Final W handshake to bvalid: 1 cycle.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch id, address and len; go to R_DATA.
  - R_DATA: issue a RAM read whenever (skid occupancy + in-flight) < 2 and beats remain to issue. RAM latency is 1 cycle; data lands in a 2-entry skid FIFO that drives rvalid/rdata/rlast.
  - Full throughput: 1 beat per cycle while rready=1. rvalid, rdata and rlast hold stable while rready=0.
  - After the final beat handshake, go to R_IDLE.
  - AR handshake at cycle 0 gives first rvalid at cycle 2.
- Simultaneous read and write of the same word in one cycle: the read returns old data.
- A new AW or AR is accepted the cycle after the previous burst's B or last-R handshake.

Optional Feature:
- Macro CNNA_AXISLV_BP_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11, advancing every cycle) gates awready, wready and arready with LFSR bits 0, 1 and 2 respectively, and holds rvalid low when bit 3 is 0. This exercises master back-pressure.
- rvalid is gated only before it asserts; it never drops once high. Functional results are unchanged.
- Undefined: no gating; the timing above is exact.

Decomposition:
- Package cnna_axislv_pkg: response codes RESP_OKAY/RESP_SLVERR; write and read state encodings; LFSR seed and tap constants.
- Reuse the existing sdpram (block style) for storage.
- One natural sub-module: axislv_skid, a 2-entry valid/ready skid FIFO with occupancy output.

Test Plan:
- Write 4 beats at 0x100 (data 0xA0..0xA3, wlast on beat 4), then read 4 beats at 0x100 -> rdata 0xA0..0xA3, rlast on beat 4 only, bresp=0, O_wlast_err=0.
- Read len=255 at 0x0 with rready=1 throughout -> 256 consecutive rvalid cycles; first rvalid 2 cycles after the AR handshake.
- Read 3 beats with rready toggling 1,0,0,1,0,1 -> no beat lost or duplicated; rdata stable while rready=0.
- Write 2 beats with wlast on beat 1 -> O_wlast_err=1; exactly 2 words written; one B response.
- Write at word address 2^C_MEM_AWIDTH-1 with len=1 -> second beat lands in word 0.
- Assert I_rst during read beat 2 of 8 -> all outputs 0 next cycle; a following 1-beat read returns the stored data.
